// File: rtl/sysbus_arb_pkg.sv
// Shared types and defaults for the two-requester system bus arbiter.
package sysbus_arb_pkg;

    localparam int BURST_BEATS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Requester index: 0 = instruction fetch, 1 = page-table walker.
    typedef logic owner_t;

endpackage

// File: rtl/sysbus_arbiter_pick.sv
// Winner selection for the two-requester arbiter. Purely combinational.
// With SYSBUS_ARB_RR_EN defined a tie goes to the requester that did not win
// last time; otherwise the walker (requester 1) always wins a tie.
module arb_pick
    import sysbus_arb_pkg::*;
(
    input  logic [1:0] reqcyc,
    input  owner_t     last_win,
    output owner_t     win
);

`ifdef SYSBUS_ARB_RR_EN
    // Tie alternates; a lone requester wins outright.
    always_comb begin
        win = reqcyc[1];
        if (&reqcyc) win = ~last_win;
    end
`else
    // Fixed priority: requester 1 wins whenever it asks.
    logic unused_last_win;
    assign unused_last_win = last_win;

    always_comb begin
        win = reqcyc[1];
    end
`endif

endmodule

// File: rtl/sysbus_arbiter.sv
// Two-requester system bus arbiter: grants one requester, forwards its latched
// address/tag to the bus, then steers BURST_BEATS response beats back to it.
// Optional macro SYSBUS_ARB_RR_EN selects round-robin tie-breaking (default
// build: fixed priority, walker wins ties).
module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BURST_BEATS    = BURST_BEATS_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  m_reqcyc,
    input  logic [2*BUS_DATA_WIDTH-1:0] m_req,
    input  logic [2*BUS_TAG_WIDTH-1:0]  m_reqtag,
    output logic [1:0]                  m_reqack,
    output logic [1:0]                  m_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]   m_resp,
    output logic [BUS_TAG_WIDTH-1:0]    m_resptag,
    input  logic [1:0]                  m_respack,
    output logic                        bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]   bus_req,
    output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
    input  logic                        bus_reqack,
    input  logic                        bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
    output logic                        bus_respack
);

    localparam int CW = $clog2(BURST_BEATS + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_BEATS - 1);

    arb_state_e state, state_nxt;
    owner_t     owner, win, last_win;
    logic [CW-1:0] beat_cnt;
    logic          grant, beat;

    // Per-requester views of the flat request buses.
    logic [1:0][BUS_DATA_WIDTH-1:0] req_addr;
    logic [1:0][BUS_TAG_WIDTH-1:0]  req_tag;
    assign req_addr = m_req;
    assign req_tag  = m_reqtag;

    arb_pick u_pick (
        .reqcyc   (m_reqcyc),
        .last_win (last_win),
        .win      (win)
    );

    assign grant      = (state == IDLE) && (|m_reqcyc);
    assign beat       = (state == RESP) && bus_respcyc && bus_respack;
    assign bus_reqcyc = (state == REQ);

    // Response data and tag are broadcast; only m_respcyc qualifies them.
    assign m_resp    = bus_resp;
    assign m_resptag = bus_resptag;

`ifdef SYSBUS_ARB_RR_EN
    // Remember who won so the other side wins the next tie.
    always_ff @(posedge clk) begin
        if (reset)      last_win <= 1'b1;
        else if (grant) last_win <= win;
    end
`else
    assign last_win = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: grant -> wait for bus accept -> drain the burst.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|m_reqcyc) state_nxt = REQ;
            REQ:     if (bus_reqack) state_nxt = RESP;
            RESP:    if (beat && (beat_cnt == LAST_BEAT)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake steering; everything toward requesters is quiet in reset.
    always_comb begin
        m_reqack    = '0;
        m_respcyc   = '0;
        bus_respack = 1'b0;
        if (!reset) begin
            if ((state == REQ) && bus_reqack) m_reqack[owner] = 1'b1;
            if (state == RESP) begin
                m_respcyc[owner] = bus_respcyc;
                bus_respack      = m_respack[owner];
            end
        end
    end

    // Latch the winner's request at grant; count acknowledged beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b0;
            beat_cnt   <= '0;
            bus_req    <= '0;
            bus_reqtag <= '0;
        end else begin
            if (grant) begin
                owner      <= win;
                bus_req    <= req_addr[win];
                bus_reqtag <= req_tag[win];
            end
            if ((state == REQ) && bus_reqack) beat_cnt <= '0;
            else if (beat)                    beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Self-checking bench for sysbus_arbiter: transaction-level reference model
// compared every cycle, directed scenarios, then randomized traffic.
module tb_sysbus_arbiter;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NB = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      m_reqcyc = '0;
    logic [2*DW-1:0] m_req = '0;
    logic [2*TW-1:0] m_reqtag = '0;
    logic [1:0]      m_reqack, m_respcyc;
    logic [DW-1:0]   m_resp;
    logic [TW-1:0]   m_resptag;
    logic [1:0]      m_respack = '0;
    logic            bus_reqcyc;
    logic [DW-1:0]   bus_req;
    logic [TW-1:0]   bus_reqtag;
    logic            bus_reqack = 1'b0;
    logic            bus_respcyc = 1'b0;
    logic [DW-1:0]   bus_resp = '0;
    logic [TW-1:0]   bus_resptag = '0;
    logic            bus_respack;

    always #5 clk = ~clk;

    sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BURST_BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqtag(m_reqtag), .m_reqack(m_reqack),
        .m_respcyc(m_respcyc), .m_resp(m_resp), .m_resptag(m_resptag), .m_respack(m_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    int chk = 0;
    int err = 0;

    // Transaction-level model: an optional in-flight transaction record.
    bit            mv = 0;
    bit            act = 0, acked = 0, own = 0, lastw = 1;
    logic [DW-1:0] addr = '0;
    logic [TW-1:0] tag = '0;
    int            beats = 0;

    // Observation counters and grant log, taken from DUT outputs.
    int n_ack0 = 0, n_beat0 = 0, n_resp1 = 0, n_reqcyc = 0;
    bit            log_own[$];
    logic [DW-1:0] log_addr[$];

    task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        chk++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic bit pick(input logic [1:0] r, input bit lw);
        bit tie_rr;
`ifdef SYSBUS_ARB_RR_EN
        tie_rr = 1'b1;
`else
        tie_rr = 1'b0;
`endif
        if (r == 2'b11) return tie_rr ? !lw : 1'b1;
        return r[1];
    endfunction

    task automatic model_cycle();
        bit         in_req, in_resp, w;
        logic [1:0] e_ack, e_rc;
        logic       e_ra;
        if (mv) begin
            in_req  = act && !acked;
            in_resp = act && acked;
            e_ack = '0; e_rc = '0; e_ra = 1'b0;
            if (!reset && in_req && bus_reqack) e_ack[own] = 1'b1;
            if (!reset && in_resp) begin
                e_rc[own] = bus_respcyc;
                e_ra      = m_respack[own];
            end
            check("bus_reqcyc", bus_reqcyc, in_req);
            check("bus_req", bus_req, addr);
            check("bus_reqtag", bus_reqtag, tag);
            check("m_reqack", m_reqack, e_ack);
            check("m_respcyc", m_respcyc, e_rc);
            check("bus_respack", bus_respack, e_ra);
            check("m_resp", m_resp, bus_resp);
            check("m_resptag", m_resptag, bus_resptag);
        end
        n_ack0   += int'(m_reqack[0]);
        n_beat0  += int'(m_respcyc[0] && bus_respack);
        n_resp1  += int'(m_respcyc[1]);
        n_reqcyc += int'(bus_reqcyc);
        if (|m_reqack) begin
            log_own.push_back(m_reqack[1]);
            log_addr.push_back(bus_req);
        end
        if (reset) begin
            act = 0; acked = 0; own = 0; addr = '0; tag = '0; beats = 0; lastw = 1; mv = 1;
        end else if (!act) begin
            if (|m_reqcyc) begin
                w = pick(m_reqcyc, lastw);
                own = w; lastw = w; act = 1; acked = 0;
                addr = w ? m_req[2*DW-1:DW] : m_req[DW-1:0];
                tag  = w ? m_reqtag[2*TW-1:TW] : m_reqtag[TW-1:0];
            end
        end else if (!acked) begin
            if (bus_reqack) begin acked = 1; beats = 0; end
        end else if (bus_respcyc && m_respack[own]) begin
            beats++;
            if (beats == NB) act = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Wait (bounded) for a bus request, accept it, then feed a full burst.
    task automatic serve();
        for (int i = 0; i < 20 && !bus_reqcyc; i++) tick();
        check("serve_wait_reqcyc", bus_reqcyc, 1);
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        bus_respcyc = 1'b1;
        m_respack = 2'b11;
        repeat (NB) tick();
        bus_respcyc = 1'b0;
        m_respack = 2'b00;
    endtask

    initial begin
        int b0, b1, b2, nl;
        bit exp0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_bus_reqcyc", bus_reqcyc, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_reqtag", bus_reqtag, 0);
        check("rst_m_reqack", m_reqack, 0);
        check("rst_m_respcyc", m_respcyc, 0);
        check("rst_bus_respack", bus_respack, 0);

        // Single fetch transaction, accept after 3 REQ cycles, 8 beats.
        m_req = '0; m_req[DW-1:0] = 64'h1000; m_reqtag = '0; m_reqtag[TW-1:0] = 13'h55;
        m_reqcyc = 2'b01;
        b0 = n_ack0; b1 = n_beat0; b2 = n_resp1;
        tick();
        m_reqcyc = 2'b00;
        check("s1_reqcyc", bus_reqcyc, 1);
        check("s1_bus_req", bus_req, 64'h1000);
        tick();
        tick();
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        check("s1_reqcyc_drop", bus_reqcyc, 0);
        bus_respcyc = 1'b1;
        m_respack = 2'b01;
        repeat (NB) tick();
        check("s1_ack0_pulses", n_ack0 - b0, 1);
        check("s1_beats0", n_beat0 - b1, NB);
        check("s1_respcyc1", n_resp1 - b2, 0);
        check("s1_idle_respack", bus_respack, 0);
        check("s1_idle_respcyc", m_respcyc, 0);
        tick();
        bus_respcyc = 1'b0;
        m_respack = 2'b00;

        // Both requesting, two back-to-back transactions.
        do_reset();
        m_req = {64'h3000, 64'h2000};
        m_reqtag = {13'h2, 13'h1};
        m_reqcyc = 2'b11;
        nl = log_own.size();
        serve();
        serve();
        m_reqcyc = 2'b00;
`ifdef SYSBUS_ARB_RR_EN
        exp0 = 1'b0;
`else
        exp0 = 1'b1;
`endif
        check("s2_ngrants", log_own.size() - nl, 2);
        if (log_own.size() >= nl + 2) begin
            check("s2_grant0_owner", log_own[nl], exp0);
            check("s2_grant0_addr", log_addr[nl], exp0 ? 64'h3000 : 64'h2000);
            check("s2_grant1_owner", log_own[nl+1], 1);
            check("s2_grant1_addr", log_addr[nl+1], 64'h3000);
        end

        // Beat acknowledged only every other cycle.
        do_reset();
        m_req[DW-1:0] = 64'h7000;
        m_reqcyc = 2'b01;
        tick();
        m_reqcyc = 2'b00;
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        b1 = n_beat0;
        bus_respcyc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_respack = (i % 2 == 1) ? 2'b01 : 2'b00;
            tick();
        end
        m_respack = 2'b01;
        check("s3_beats", n_beat0 - b1, NB);
        check("s3_idle_respack", bus_respack, 0);
        bus_respcyc = 1'b0;
        m_respack = 2'b00;

        // Walker arrives during fetch burst; must wait, then get its address.
        do_reset();
        m_req = {64'h5000, 64'h4000};
        m_reqtag = {13'h45, 13'h44};
        m_reqcyc = 2'b01;
        tick();
        m_reqcyc = 2'b00;
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        m_reqcyc = 2'b10;
        b0 = n_reqcyc;
        bus_respcyc = 1'b1;
        m_respack = 2'b11;
        repeat (NB) tick();
        bus_respcyc = 1'b0;
        check("s4_no_reqcyc_in_resp", n_reqcyc - b0, 0);
        check("s4_idle_reqcyc", bus_reqcyc, 0);
        tick();
        check("s4_grant_reqcyc", bus_reqcyc, 1);
        check("s4_grant_addr", bus_req, 64'h5000);
        check("s4_grant_tag", bus_reqtag, 13'h45);
        nl = log_own.size();
        serve();
        m_reqcyc = 2'b00;
        check("s4_ngrants", log_own.size() - nl, 1);
        if (log_own.size() > nl) check("s4_owner", log_own[nl], 1);

        // Reset in the middle of a burst.
        do_reset();
        m_req = {64'h6000, 64'h8000};
        m_reqcyc = 2'b01;
        tick();
        m_reqcyc = 2'b00;
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        bus_respcyc = 1'b1;
        m_respack = 2'b01;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("s5_rst_respack", bus_respack, 0);
        check("s5_rst_respcyc", m_respcyc, 0);
        tick();
        reset = 1'b0;
        #1;
        check("s5_after_reqcyc", bus_reqcyc, 0);
        check("s5_after_respack", bus_respack, 0);
        check("s5_after_respcyc", m_respcyc, 0);
        bus_respcyc = 1'b0;
        m_respack = 2'b00;
        m_reqcyc = 2'b10;
        tick();
        m_reqcyc = 2'b00;
        check("s5_new_reqcyc", bus_reqcyc, 1);
        check("s5_new_addr", bus_req, 64'h6000);
        serve();

        // Randomized traffic, model checks every cycle.
        repeat (3000) begin
            reset       = ($urandom_range(63) == 0);
            m_reqcyc    = 2'($urandom);
            m_req       = {$urandom, $urandom, $urandom, $urandom};
            m_reqtag    = 26'($urandom);
            m_respack   = 2'($urandom);
            bus_reqack  = ($urandom_range(2) == 0);
            bus_respcyc = ($urandom_range(3) != 0);
            bus_resp    = {$urandom, $urandom};
            bus_resptag = 13'($urandom);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, the width of the request address and response data.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, the width of the request and response tags.
REQ-003 SHALL have parameter BURST_BEATS, default 8, the number of response beats per transaction (one 64-byte line).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port m_reqcyc, input, 2 bits: per-requester request valid (bit 0 = instruction fetch, bit 1 = page-table walker).
REQ-007 SHALL have port m_req, input, 2*BUS_DATA_WIDTH bits: per-requester address, slice i = requester i.
REQ-008 SHALL have port m_reqtag, input, 2*BUS_TAG_WIDTH bits: per-requester request tag.
REQ-009 SHALL have port m_reqack, output, 2 bits: per-requester one-cycle acceptance pulse.
REQ-010 SHALL have port m_respcyc, output, 2 bits: per-requester response beat valid.
REQ-011 SHALL have port m_resp, output, BUS_DATA_WIDTH bits: response data, broadcast to both requesters.
REQ-012 SHALL have port m_resptag, output, BUS_TAG_WIDTH bits: response tag, broadcast to both requesters.
REQ-013 SHALL have port m_respack, input, 2 bits: per-requester beat acknowledge.
REQ-014 SHALL have ports bus_reqcyc (out, 1), bus_req (out, BUS_DATA_WIDTH), bus_reqtag (out, BUS_TAG_WIDTH), bus_reqack (in, 1), bus_respcyc (in, 1), bus_resp (in, BUS_DATA_WIDTH), bus_resptag (in, BUS_TAG_WIDTH) and bus_respack (out, 1): the shared system bus.

Function
REQ-015 SHALL implement FSM states IDLE, REQ and RESP, with a 1-bit owner register and a beat counter of width $clog2(BURST_BEATS+1).
REQ-016 SHALL, in IDLE with any m_reqcyc bit set, pick a winner, latch owner, latch its m_req and m_reqtag into bus_req and bus_reqtag, and enter REQ; bus_reqcyc SHALL be 1 from the next cycle.
REQ-017 SHALL, in REQ, hold bus_reqcyc=1 and keep bus_req and bus_reqtag stable until bus_reqack=1.
REQ-018 SHALL, in the bus_reqack cycle, pulse m_reqack[owner]=1 for exactly that cycle, deassert bus_reqcyc on the next cycle, clear the beat counter and enter RESP.
REQ-019 SHALL, in RESP, drive m_respcyc[owner]=bus_respcyc and bus_respack=m_respack[owner] combinationally; the non-owner's m_respcyc SHALL be 0.
REQ-020 SHALL count a beat only in a cycle where bus_respcyc && bus_respack; after beat BURST_BEATS it SHALL return to IDLE in the next cycle.
REQ-021 SHALL not sample new requests in REQ or RESP; a competing request waits without loss, and the earliest re-grant is the cycle after the return to IDLE.
REQ-022 SHALL force bus_respack=0 and all m_respcyc bits to 0 outside RESP, and a bus_respcyc arriving in IDLE or REQ SHALL be ignored.
REQ-023 SHALL ignore a requester dropping m_reqcyc after grant; the transaction completes with the latched address and tag.
REQ-024 SHALL, when both requesters are pending, pick per REQ-029.

Reset
REQ-025 SHALL, on reset, set state=IDLE, owner=0, beat counter=0, last-winner=1 (so requester 0 has priority first), bus_reqcyc=0, bus_req=0 and bus_reqtag=0.
REQ-026 SHALL hold bus_respack=0, m_reqack=0 and m_respcyc=0 during reset.
REQ-027 SHALL let reset asserted mid-REQ or mid-RESP abandon the transaction immediately, without draining remaining beats.

Configuration
REQ-028 SHALL use macro SYSBUS_ARB_RR_EN.
REQ-029 SHALL, when SYSBUS_ARB_RR_EN is defined, grant round-robin (the requester that did not win last grant wins a tie); when undefined, grant fixed priority with requester 1 (walker) always winning a tie and no last-winner register.

Structure
REQ-030 SHALL place the state enum, the owner type and the BURST_BEATS default in shared package sysbus_arb_pkg.
REQ-031 SHALL contain exactly one combinational sub-module, arb_pick, computing the winner from m_reqcyc and last-winner.

Verification
REQ-032 SHALL cover: m_reqcyc=01, m_req=0x1000, bus_reqack after 3 cycles, 8 acked beats -> bus_req=0x1000, one m_reqack[0] pulse, 8 m_respcyc[0] beats, m_respcyc[1]=0 throughout, IDLE after beat 8.
REQ-033 SHALL cover: m_reqcyc=11 for two back-to-back transactions -> with SYSBUS_ARB_RR_EN the grant order is 0 then 1; without it the order is 1 then 1.
REQ-034 SHALL cover: bus_respcyc held high with m_respack toggling every other cycle -> exactly 8 counted beats in 16 cycles, then return to IDLE.
REQ-035 SHALL cover: requester 1 raising m_reqcyc during requester 0's RESP -> no bus_reqcyc until requester 0's beat 8, then requester 1 granted with its own address.
REQ-036 SHALL cover: reset at beat 4 -> next cycle shows IDLE, bus_reqcyc=0, bus_respack=0, and a new request is accepted normally.
REQ-037 SHALL cover: spurious bus_respcyc in IDLE -> bus_respack=0 and no m_respcyc asserted.
